// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, bubbles decode while a
// branch is outstanding, then resumes or redirects when execute resolves it.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          BR_TIMEOUT = 8,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             pc_nop_control,
  input  logic             br_resolve,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic             if_id_valid,
  output logic             br_timeout_err,
  output logic             misalign_err,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int             WC_W = $clog2(BR_TIMEOUT + 1) + 1;
  localparam logic [WC_W-1:0] TMO = WC_W'(BR_TIMEOUT);

  typedef enum logic {FETCH, WAIT_BR} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_pc, w_pc_nxt;
  logic [31:0]     r_instr, r_ifid_pc;
  logic            r_valid;
  logic [WC_W-1:0] r_wait_cnt, w_wait_sat;
  logic            r_tmo_err, r_mis_err;
  logic [CNT_W-1:0] r_bcnt;
  logic            w_load, w_bubble, w_wait_clr, w_wait_inc, w_mis_set;

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_ifid_pc;
  assign if_id_valid    = r_valid;
  assign br_timeout_err = r_tmo_err;
  assign misalign_err   = r_mis_err;
  assign bubble_cnt     = r_bcnt;

  assign w_wait_sat = (r_wait_cnt == TMO) ? TMO : r_wait_cnt + 1'b1;

  // Priority: resolve > WAIT_BR bubbling (ignores stall) > stall > nop request > fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_wait_clr  = 1'b0;
    w_wait_inc  = 1'b0;
    w_mis_set   = 1'b0;
    if (br_resolve) begin
      w_load      = 1'b1;
      w_bubble    = 1'b1;
      w_pc_nxt    = br_taken ? {br_target[31:2], 2'b00} : r_pc;
      w_state_nxt = FETCH;
      w_wait_clr  = 1'b1;
      w_mis_set   = br_taken && (br_target[1:0] != 2'b00);
    end else if (r_state == WAIT_BR) begin
      w_load     = 1'b1;
      w_bubble   = 1'b1;
      w_wait_inc = 1'b1;
    end else if (stall) begin
      w_load = 1'b0;
    end else if (pc_nop_control) begin
      w_load      = 1'b1;
      w_bubble    = 1'b1;
      w_state_nxt = WAIT_BR;
      w_wait_clr  = 1'b1;
    end else begin
      w_load   = 1'b1;
      w_pc_nxt = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_ifid_pc  <= '0;
      r_valid    <= 1'b0;
      r_wait_cnt <= '0;
      r_tmo_err  <= 1'b0;
      r_mis_err  <= 1'b0;
      r_bcnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_load) begin
        r_instr   <= w_bubble ? 32'h0 : imem_rdata;
        r_ifid_pc <= r_pc;
        r_valid   <= !w_bubble;
      end
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= w_wait_sat;
        if (w_wait_sat == TMO) r_tmo_err <= 1'b1;
      end
      if (w_mis_set) r_mis_err <= 1'b1;
      if (w_bubble && (r_bcnt != '1)) r_bcnt <= r_bcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand sequences for
// timeout, misaligned redirect, counter saturation, PC wrap and reset during WAIT_BR.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, nop, res, tk;
  logic [31:0] tgt;
  logic [31:0] addr, rdata, instr, ifpc;
  logic        vld, tmo, mis;
  logic [15:0] bcnt;
  logic [31:0] w_addr, w_rdata, w_instr, w_ifpc;
  logic        w_vld, w_tmo, w_mis;
  logic [2:0]  w_bcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign rdata   = mem(addr);
  assign w_rdata = mem(w_addr);

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr), .imem_rdata(rdata),
    .stall(stall), .pc_nop_control(nop), .br_resolve(res), .br_taken(tk),
    .br_target(tgt), .if_id_instr(instr), .if_id_pc(ifpc), .if_id_valid(vld),
    .br_timeout_err(tmo), .misalign_err(mis), .bubble_cnt(bcnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .BR_TIMEOUT(8), .CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(stall), .pc_nop_control(nop), .br_resolve(res), .br_taken(tk),
    .br_target(tgt), .if_id_instr(w_instr), .if_id_pc(w_ifpc), .if_id_valid(w_vld),
    .br_timeout_err(w_tmo), .misalign_err(w_mis), .bubble_cnt(w_bcnt)
  );

  typedef struct {
    logic        rst_n, stall, nop, res, tk;
    logic [31:0] tgt;
    logic [31:0] e_ifpc;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [15:0] e_bcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, s, n, rs, t, input logic [31:0] tg,
                             input logic [31:0] ip, input logic ev,
                             input logic [31:0] ep, input logic [15:0] eb);
    vec_t x;
    x.rst_n = r; x.stall = s; x.nop = n; x.res = rs; x.tk = t; x.tgt = tg;
    x.e_ifpc = ip; x.e_vld = ev; x.e_pc = ep; x.e_bcnt = eb;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, s, n, rs, t, input logic [31:0] tg);
    rst_n = r; stall = s; nop = n; res = rs; tk = t; tgt = tg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; nop = 1'b0; res = 1'b0; tk = 1'b0; tgt = '0;

    // args: rst stall nop res tk tgt | if_id_pc valid pc bubble_cnt
    // 1: straight-line fetch from reset
    tbl.push_back(v(0,0,0,0,0,0,  32'h0,  0, 32'h0,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h0,  1, 32'h4,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h4,  1, 32'h8,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h8,  1, 32'hC,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'hC,  1, 32'h10, 0));
    // 2: branch at 8 in decode, taken to 0x40
    tbl.push_back(v(0,0,0,0,0,0,  32'h0,  0, 32'h0,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h0,  1, 32'h4,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h4,  1, 32'h8,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h8,  1, 32'hC,  0));
    tbl.push_back(v(1,0,1,0,0,0,  32'hC,  0, 32'hC,  1));
    tbl.push_back(v(1,0,0,0,0,0,  32'hC,  0, 32'hC,  2));
    tbl.push_back(v(1,0,0,0,0,0,  32'hC,  0, 32'hC,  3));
    tbl.push_back(v(1,0,0,1,1,32'h40, 32'hC, 0, 32'h40, 4));
    tbl.push_back(v(1,0,0,0,0,0,  32'h40, 1, 32'h44, 4));
    // 3: same branch not taken, resumes at 0xC
    tbl.push_back(v(0,0,0,0,0,0,  32'h0,  0, 32'h0,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h0,  1, 32'h4,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h4,  1, 32'h8,  0));
    tbl.push_back(v(1,0,0,0,0,0,  32'h8,  1, 32'hC,  0));
    tbl.push_back(v(1,0,1,0,0,0,  32'hC,  0, 32'hC,  1));
    tbl.push_back(v(1,0,0,0,0,0,  32'hC,  0, 32'hC,  2));
    tbl.push_back(v(1,0,0,0,0,0,  32'hC,  0, 32'hC,  3));
    tbl.push_back(v(1,0,0,1,0,32'h40, 32'hC, 0, 32'hC,  4));
    tbl.push_back(v(1,0,0,0,0,0,  32'hC,  1, 32'h10, 4));
    tbl.push_back(v(1,0,0,0,0,0,  32'h10, 1, 32'h14, 4));
    // 4: stall hold, stall+resolve, stall over nop, stall ignored in WAIT_BR
    tbl.push_back(v(1,1,0,0,0,0,  32'h10, 1, 32'h14, 4));
    tbl.push_back(v(1,1,0,0,0,0,  32'h10, 1, 32'h14, 4));
    tbl.push_back(v(1,1,0,0,0,0,  32'h10, 1, 32'h14, 4));
    tbl.push_back(v(1,0,0,0,0,0,  32'h14, 1, 32'h18, 4));
    tbl.push_back(v(1,1,0,1,1,32'h80, 32'h18, 0, 32'h80, 5));
    tbl.push_back(v(1,0,0,0,0,0,  32'h80, 1, 32'h84, 5));
    tbl.push_back(v(1,1,1,0,0,0,  32'h80, 1, 32'h84, 5));
    tbl.push_back(v(1,0,1,0,0,0,  32'h84, 0, 32'h84, 6));
    tbl.push_back(v(1,1,0,0,0,0,  32'h84, 0, 32'h84, 7));
    tbl.push_back(v(1,0,0,1,0,0,  32'h84, 0, 32'h84, 8));
    tbl.push_back(v(1,0,0,0,0,0,  32'h84, 1, 32'h88, 8));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].stall, tbl[i].nop, tbl[i].res, tbl[i].tk, tbl[i].tgt);
      chk($sformatf("v%0d.if_id_pc", i), ifpc, tbl[i].e_ifpc);
      chk($sformatf("v%0d.valid", i), {31'b0, vld}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d.instr", i), instr, tbl[i].e_vld ? mem(tbl[i].e_ifpc) : 32'h0);
      chk($sformatf("v%0d.imem_addr", i), addr, tbl[i].e_pc);
      chk($sformatf("v%0d.bubble_cnt", i), {16'b0, bcnt}, {16'b0, tbl[i].e_bcnt});
    end
    chk("tbl.misalign", {31'b0, mis}, 32'h0);
    chk("tbl.timeout", {31'b0, tmo}, 32'h0);

    // 5: timeout, sticky flag, misaligned redirect; small-counter saturation
    step(0,0,0,0,0,0);
    step(1,0,1,0,0,0);
    for (int k = 1; k <= 10; k++) begin
      step(1,0,0,0,0,0);
      if (k == 5) chk("tmo.early", {31'b0, tmo}, 32'h0);
      if (k == 6) chk("sat.reach", {29'b0, w_bcnt}, 32'h7);
    end
    chk("tmo.set", {31'b0, tmo}, 32'h1);
    chk("sat.hold", {29'b0, w_bcnt}, 32'h7);
    chk("tmo.bcnt", {16'b0, bcnt}, 32'd11);
    step(1,0,0,1,1,32'h42);
    chk("mis.pc", addr, 32'h40);
    chk("mis.flag", {31'b0, mis}, 32'h1);
    chk("tmo.sticky", {31'b0, tmo}, 32'h1);
    step(1,0,0,0,0,0);
    chk("mis.fetch_pc", ifpc, 32'h40);
    chk("mis.fetch_vld", {31'b0, vld}, 32'h1);
    chk("mis.sticky", {31'b0, mis}, 32'h1);

    // 6: PC wrap from FFFF_FFF8
    step(0,0,0,0,0,0);
    chk("wrap.reset_pc", w_addr, 32'hFFFF_FFF8);
    chk("wrap.bcnt0", {29'b0, w_bcnt}, 32'h0);
    step(1,0,0,0,0,0);
    chk("wrap.pc1", w_addr, 32'hFFFF_FFFC);
    chk("wrap.ifpc1", w_ifpc, 32'hFFFF_FFF8);
    chk("wrap.instr1", w_instr, mem(32'hFFFF_FFF8));
    step(1,0,0,0,0,0);
    chk("wrap.pc2", w_addr, 32'h0);
    chk("wrap.ifpc2", w_ifpc, 32'hFFFF_FFFC);
    step(1,0,0,0,0,0);
    chk("wrap.ifpc3", w_ifpc, 32'h0);

    // reset while waiting on a branch discards it
    step(1,0,1,0,0,0);
    for (int k = 0; k < 9; k++) step(1,0,0,0,0,0);
    chk("rstw.tmo_before", {31'b0, tmo}, 32'h1);
    step(0,0,0,0,0,0);
    chk("rstw.pc", addr, 32'h0);
    chk("rstw.w_pc", w_addr, 32'hFFFF_FFF8);
    chk("rstw.ifpc", ifpc, 32'h0);
    chk("rstw.instr", instr, 32'h0);
    chk("rstw.vld", {31'b0, vld}, 32'h0);
    chk("rstw.bcnt", {16'b0, bcnt}, 32'h0);
    chk("rstw.tmo", {31'b0, tmo}, 32'h0);
    chk("rstw.mis", {31'b0, mis}, 32'h0);
    step(1,0,0,0,0,0);
    chk("rstw.fetch_vld", {31'b0, vld}, 32'h1);
    chk("rstw.fetch_pc", addr, 32'h4);
    chk("rstw.fetch_instr", instr, mem(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
